// File: rtl/imm_ext_pipe_pkg.sv
// imm_ext_pipe_pkg
// Shared CPU control encodings for the immediate-extension path, plus the
// fixed geometry of the result buffer.
//   ext_op_e : extension-mode encoding carried on in_op
//   DEPTH    : result buffer entry count (fixed, not a module parameter)
//   PTR_W    : buffer pointer width
//   CNT_W    : occupancy counter width (holds 0..DEPTH)
package imm_ext_pipe_pkg;

   typedef enum logic [1:0] {
      EXT_ZERO = 2'b00,
      EXT_SIGN = 2'b01,
      EXT_HIGH = 2'b10,
      EXT_BOFF = 2'b11
   } ext_op_e;

   localparam int DEPTH = 2;
   localparam int PTR_W = 1;
   localparam int CNT_W = 2;

endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core
// Pure combinational immediate extension.
//   in_imm  [IN_W-1:0]  raw immediate field
//   in_op   [1:0]       extension mode (ext_op_e)
//   result  [OUT_W-1:0] extended word
module imm_ext_core
   import imm_ext_pipe_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_op,
   output logic [OUT_W-1:0] result
);

   logic [OUT_W-1:0] sext;

   assign sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

   always_comb begin
      result = '0;
      case (ext_op_e'(in_op))
         EXT_ZERO: result = {{(OUT_W-IN_W){1'b0}}, in_imm};
         EXT_SIGN: result = sext;
         EXT_HIGH: result = {in_imm, {(OUT_W-IN_W){1'b0}}};
         // Word-aligned branch offset; bits shifted past the top are dropped.
         EXT_BOFF: result = sext << 2;
      endcase
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe
// Extends an immediate at acceptance and holds the result in a two-entry
// FIFO with valid/ready handshakes on both sides.
//   clk       clock, rising edge
//   reset     synchronous, active-low
//   in_valid  upstream offer          in_ready  can accept this cycle
//   in_imm    raw immediate           in_op     extension mode
//   out_valid head entry valid        out_ready downstream consumes
//   out_data  head entry              flush     drop all buffered results
module imm_ext_pipe
   import imm_ext_pipe_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   input  logic             flush
);

   logic [OUT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [OUT_W-1:0] ext_word;
   logic             accept;
   logic             consume;

   imm_ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .in_imm (in_imm),
      .in_op  (in_op),
      .result (ext_word)
   );

   // Handshake flags come only from the registered count, so there is no
   // combinational path from out_ready to in_ready.
   assign in_ready  = (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];

   assign accept  = in_valid & in_ready;
   assign consume = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         // Realign the pointers so the next accept lands at the head.
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= ext_word;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (consume) rd_ptr <= rd_ptr + 1'b1;
         case ({accept, consume})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 Parameter IN_W, default 16, width of the raw immediate field (legal range 1..OUT_W-1).
REQ-002 Parameter OUT_W, default 32, width of the extended datapath word.
REQ-003 Parameter DEPTH, fixed at 2; it is the buffer entry count and is not overridable.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 in_valid  input  1  upstream offers an immediate this cycle.
REQ-007 in_ready  output  1  block can accept an offer this cycle.
REQ-008 in_imm  input  IN_W  raw immediate field.
REQ-009 in_op  input  2  extension mode: 00 zero-ext, 01 sign-ext, 10 load-high, 11 branch-offset.
REQ-010 out_valid  output  1  out_data holds a valid extended word.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 out_data  output  OUT_W  extended result.
REQ-013 flush  input  1  discard all buffered results (pipeline flush on branch/exception).

Function
REQ-014 Zero-ext (00): out = {(OUT_W-IN_W) zeros, in_imm}.
REQ-015 Sign-ext (01): out = {(OUT_W-IN_W) copies of in_imm[IN_W-1], in_imm}.
REQ-016 Load-high (10): out = in_imm placed in bits [OUT_W-1 : OUT_W-IN_W], low bits zero.
REQ-017 Branch-offset (11): out = sign-extended in_imm shifted left by 2, bits above OUT_W-1 discarded.
REQ-018 Extension is computed at acceptance; each buffer entry stores the OUT_W result, not the raw field.
REQ-019 Accept occurs in a cycle when in_valid=1 and in_ready=1; consume occurs when out_valid=1 and out_ready=1.
REQ-020 Latency: a result accepted in cycle N is presented on out_data in cycle N+1 at the earliest.
REQ-021 Buffer is a DEPTH-entry FIFO; results leave in acceptance order.
REQ-022 Occupancy count is 0..2; in_ready = (count != 2), derived from registered state only (no combinational path from out_ready).
REQ-023 out_valid = (count != 0); out_data = head entry; out_data is don't-care when out_valid=0 but SHALL be 0 after reset.
REQ-024 Accept and consume in the same cycle with count=1: count stays 1, new entry becomes head next cycle.
REQ-025 Accept and consume in the same cycle with count=0 is impossible (out_valid=0); count becomes 1.
REQ-026 With count=2, in_ready=0; in_valid is ignored; consume drops count to 1 and in_ready rises next cycle.
REQ-027 Flush=1: count becomes 0 next cycle; a same-cycle offer is not accepted; a same-cycle consume has no additional effect.
REQ-028 Flush takes priority over accept; reset takes priority over flush.
REQ-029 Upstream holds in_imm/in_op stable while in_valid=1 and in_ready=0; the block does not check this.
REQ-030 Read/write pointers wrap modulo DEPTH.

Reset
REQ-031 When reset=0 at a rising edge: count=0, pointers=0, all entries=0.
REQ-032 Outputs after reset: out_valid=0, in_ready=1, out_data=0.
REQ-033 Reset asserted mid-transfer discards all entries with no output of partial data.

Structure
REQ-034 Extension-mode encodings (EXT_ZERO, EXT_SIGN, EXT_HIGH, EXT_BOFF) are defined in the shared CPU definitions package alongside other control encodings.
REQ-035 The pure combinational extension function is one sub-module, imm_ext_core (IN_W, OUT_W, in_op -> result); the buffer and handshake logic live in imm_ext_pipe.

Verification
REQ-036 IN_W=16, OUT_W=32, imm=16'h8001, modes 00/01/10/11 in sequence, out_ready=1 -> out_data 32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004, each one cycle after acceptance.
REQ-037 out_ready=0, offer 3 items -> first two accepted, in_ready=0 from cycle after 2nd accept; raise out_ready -> items emerge in order, third accepted when in_ready returns to 1.
REQ-038 count=1, simultaneous accept (imm=16'h0005, sign) and consume -> out_valid stays 1, next out_data 32'h00000005, count stays 1.
REQ-039 count=2, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered item absent from output.
REQ-040 count=2, reset=0 for one cycle -> out_valid=0, in_ready=1, out_data=0; no stale entry emerges afterwards.
REQ-041 IN_W=5, OUT_W=32, imm=5'h1F, zero-ext -> out_data 32'h0000001F; sign-ext -> 32'hFFFFFFFF.
